// File: rtl/spi_regbank.sv
// SPI register bank: window decode, local writable registers, read-only status mux,
// burst transfers with optional pointer auto-increment and per-register access strobes.
module spi_regbank #(
    parameter int unsigned                          ADDR_W    = 7,
    parameter int unsigned                          DATA_W    = 8,
    parameter int unsigned                          NUM_REGS  = 8,
    parameter int unsigned                          BASE_ADDR = 4,
    parameter logic [NUM_REGS-1:0]                  RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]           RST_VAL   = '0,
    parameter bit                                   AUTO_INC  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            reg_addr,
    input  logic                         addr_dv,
    input  logic                         rw_out,
    input  logic                         rxdv,
    input  logic [DATA_W-1:0]            rx_d,
    input  logic                         tx_ack,
    output logic [DATA_W-1:0]            tx_d,
    output logic                         tx_en,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_stb,
    output logic [NUM_REGS-1:0]          rd_stb,
    output logic                         addr_err
);

    localparam int unsigned REG_BITS = NUM_REGS * DATA_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_FETCH = 2'd2,
        RD_HOLD  = 2'd3
    } state_t;

    // Expand the per-register read-only mask to a per-bit mask over the flat register vector.
    function automatic logic [REG_BITS-1:0] expand_ro_mask();
        logic [REG_BITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) m[i*DATA_W +: DATA_W] = {DATA_W{1'b1}};
        end
        return m;
    endfunction

    // Read-only slices are never stored, so they reset to and stay at zero.
    localparam logic [REG_BITS-1:0] RO_BITS   = expand_ro_mask();
    localparam logic [REG_BITS-1:0] REG_RESET = RST_VAL & ~RO_BITS;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [REG_BITS-1:0]    regs_q, regs_d;
    logic                   addr_dv_q;
    logic                   armed_q;
    logic [DATA_W-1:0]      tx_d_nxt;
    logic                   tx_en_nxt;
    logic [NUM_REGS-1:0]    wr_stb_nxt;
    logic [NUM_REGS-1:0]    rd_stb_nxt;
    logic                   addr_err_nxt;

    logic [NUM_REGS-1:0]    sel;
    logic                   in_range;
    logic                   is_ro;
    logic [DATA_W-1:0]      rd_data;
    logic [ADDR_W-1:0]      ptr_adv;
    logic                   dv_rise;

    // A rise only counts once addr_dv has been seen low after reset.
    assign dv_rise = addr_dv & ~addr_dv_q & armed_q;
    assign reg_q   = regs_q;

    // Pointer decode: one-hot register select, range/RO flags, read mux and next pointer.
    always_comb begin
        sel     = '0;
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            sel[i] = (ptr_q == ADDR_W'(i));
            if (sel[i]) begin
                rd_data = RO_MASK[i] ? ro_d[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
            end
        end
        in_range = |sel;
        is_ro    = |(sel & RO_MASK);
        if (AUTO_INC && in_range) begin
            ptr_adv = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + ADDR_W'(1);
        end else begin
            ptr_adv = ptr_q;
        end
    end

    // Next-state and datapath update for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        tx_d_nxt     = tx_d;
        tx_en_nxt    = tx_en;
        wr_stb_nxt   = '0;
        rd_stb_nxt   = '0;
        addr_err_nxt = 1'b0;

        if ((state_q != IDLE) && !addr_dv) begin
            state_d   = IDLE;
            tx_en_nxt = 1'b0;
            tx_d_nxt  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dv_rise) begin
                        ptr_d   = reg_addr - ADDR_W'(BASE_ADDR);
                        state_d = rw_out ? RD_FETCH : WR;
                    end
                end
                WR: begin
                    if (rxdv) begin
                        if (in_range && !is_ro) begin
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                if (sel[i]) regs_d[i*DATA_W +: DATA_W] = rx_d;
                            end
                            wr_stb_nxt = sel;
                        end else begin
                            addr_err_nxt = 1'b1;
                        end
                        ptr_d = ptr_adv;
                    end
                end
                RD_FETCH: begin
                    tx_en_nxt = 1'b1;
                    state_d   = RD_HOLD;
                    if (in_range) begin
                        tx_d_nxt   = rd_data;
                        rd_stb_nxt = sel;
                    end else begin
                        tx_d_nxt     = '0;
                        addr_err_nxt = 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (tx_ack) begin
                        ptr_d   = ptr_adv;
                        state_d = RD_FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, register storage, registered outputs and addr_dv edge tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            regs_q    <= REG_RESET;
            tx_d      <= '0;
            tx_en     <= 1'b0;
            wr_stb    <= '0;
            rd_stb    <= '0;
            addr_err  <= 1'b0;
            addr_dv_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            regs_q    <= regs_d;
            tx_d      <= tx_d_nxt;
            tx_en     <= tx_en_nxt;
            wr_stb    <= wr_stb_nxt;
            rd_stb    <= rd_stb_nxt;
            addr_err  <= addr_err_nxt;
            addr_dv_q <= addr_dv;
            armed_q   <= armed_q | ~addr_dv;
        end
    end

endmodule
